rf_dump_reader: RTL

Debug/trace reader that walks a contiguous, optionally wrapping, range of the 32×32 register file through one of its combinational read ports. It streams each register's value out over a valid/ready interface, tagged with its address. It sits beside the single-cycle CPU datapath and borrows a read port (muxed by the top level while `busy_o` is high) to dump architectural state to a debug/UART front end.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_dump_reader.sv | 86 ++++++++
 2 files changed

// File: rtl/rf_pkg.sv
// Constants and types shared between the register file and the modules
// that read from it.
package rf_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND
    } rf_dump_state_t;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks a (possibly wrapping) register-file address range through a borrowed
// read port and streams each value out over valid/ready, tagged with its address.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start_i; range is captured on start
// READ    | ra_o = ptr; rd_i and the beat tags are captured at the edge
// SEND    | beat held on out_* until accepted; then next address or done
module rf_dump_reader
    import rf_pkg::*;
#(
    parameter int NUM_REGS = rf_pkg::NUM_REGS,
    parameter int ADDR_W   = rf_pkg::REG_ADDR_W,
    parameter int DATA_W   = rf_pkg::REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_i,
    input  logic [ADDR_W-1:0] last_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] ra_o,
    input  logic [DATA_W-1:0] rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_last_o
);

    rf_dump_state_t    state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] last_q;

    // The read address comes straight from the pointer register, so nothing
    // on the sink side can reach the register-file port combinationally.
    assign ra_o   = ptr;
    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            last_q      <= '0;
            done_o      <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_addr_o  <= '0;
            out_last_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        ptr    <= first_i;
                        last_q <= last_i;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    out_data_o  <= rd_i;
                    out_addr_o  <= ptr;
                    out_last_o  <= (ptr == last_q);
                    out_valid_o <= 1'b1;
                    state       <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        if (out_last_o) begin
                            done_o <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            // Wraps through the top address back to 0.
                            ptr   <= ADDR_W'((int'(ptr) + 1) % NUM_REGS);
                            state <= ST_READ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
